// File: rtl/hsv_pkg.sv
// Shared constants, encodings and reciprocal-table generators for the RGB565->HSV
// front end. The colour classifier uses the same generators for its thresholds.
package hsv_pkg;

  localparam int HUE_MAX    = 360;
  localparam int RECIP_FRAC = 10;

  typedef enum logic [1:0] {
    SEL_R = 2'd0,
    SEL_G = 2'd1,
    SEL_B = 2'd2
  } sel_t;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } phase_t;

  // Rounded integer division; a zero denominator yields table entry 0.
  function automatic int recip_round(input int num, input int den);
    if (den == 0) return 0;
    return (2 * num + den) / (2 * den);
  endfunction

  function automatic int recip60_entry(input int d, input int frac);
    return recip_round(60 << frac, d);
  endfunction

  function automatic int recip31_entry(input int m, input int frac);
    return recip_round(31 << frac, m);
  endfunction

  function automatic logic [8:0] hue_base(input sel_t sel);
    case (sel)
      SEL_G:   return 9'd120;
      SEL_B:   return 9'd240;
      default: return 9'd0;
    endcase
  endfunction

endpackage

// File: rtl/hsv_recip_rom.sv
// Two 32-entry constant reciprocal ROMs: RECIP60[d] scales hue, RECIP31[m] scales
// saturation. Contents are elaborated from the package generators.
module hsv_recip_rom
  import hsv_pkg::*;
#(
  parameter int FRAC = 10,
  localparam int W   = FRAC + 6
) (
  input  logic [4:0]   delta,
  input  logic [4:0]   max_val,
  output logic [W-1:0] recip60,
  output logic [W-1:0] recip31
);

  logic [W-1:0] rom60 [32];
  logic [W-1:0] rom31 [32];

  for (genvar i = 0; i < 32; i++) begin : g_rom
    assign rom60[i] = W'(recip60_entry(i, FRAC));
    assign rom31[i] = W'(recip31_entry(i, FRAC));
  end

  assign recip60 = rom60[delta];
  assign recip31 = rom31[max_val];

endmodule

// File: rtl/rgb565_to_hsv.sv
// Camera byte-pair assembler plus 3-stage RGB565->HSV pipeline feeding the ball
// classifier. Define RGB_DEBUG_EN to add the dbg_rgb565 source-pixel output.
module rgb565_to_hsv
  import hsv_pkg::*;
#(
  parameter int H_PIXELS   = 640,
  parameter int RECIP_FRAC = hsv_pkg::RECIP_FRAC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cam_data,
  input  logic       cam_byte_valid,
  input  logic       cam_href,
  input  logic       cam_vsync,
  output logic [8:0] hue,
  output logic [4:0] saturation,
  output logic [4:0] value,
  output logic       write,
  output logic [9:0] horiz_count
`ifdef RGB_DEBUG_EN
  ,
  output logic [15:0] dbg_rgb565
`endif
);

  localparam int RW = RECIP_FRAC + 6;
  localparam int PW = RW + 6;
  localparam logic [PW-1:0] ROUND    = PW'(1 << (RECIP_FRAC - 1));
  localparam logic [9:0]    LINE_END = 10'(H_PIXELS);

  phase_t     phase, phase_next;
  logic [7:0] hi_byte;
  logic       href_d;
  logic [9:0] pix_cnt;
  logic       accept, issue, line_flush;

  assign accept     = cam_byte_valid && cam_href && !cam_vsync;
  assign issue      = accept && (phase == SECOND) && (pix_cnt < LINE_END);
  assign line_flush = cam_vsync || (href_d && !cam_href);

  always_ff @(posedge clk) begin
    if (!rst_n) phase <= FIRST;
    else        phase <= phase_next;
  end

  // Losing href or seeing vsync discards any half-assembled pixel.
  always_comb begin
    phase_next = phase;
    if (cam_vsync || !cam_href) begin
      phase_next = FIRST;
    end else if (cam_byte_valid) begin
      phase_next = (phase == FIRST) ? SECOND : FIRST;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_byte <= 8'd0;
      href_d  <= 1'b0;
      pix_cnt <= 10'd0;
    end else begin
      href_d <= cam_href;
      if (accept && phase == FIRST) hi_byte <= cam_data;
      if (line_flush)  pix_cnt <= 10'd0;
      else if (issue)  pix_cnt <= pix_cnt + 10'd1;
    end
  end

  // The green LSB of RGB565 is not carried into the 5-bit HSV domain.
  logic unused_g_lsb;
  assign unused_g_lsb = cam_data[5];

  logic [4:0]        r5, g5, b5, max_c, min_c;
  sel_t              sel_c;
  logic signed [5:0] diff_c;

  assign r5 = hi_byte[7:3];
  assign g5 = {hi_byte[2:0], cam_data[7:6]};
  assign b5 = cam_data[4:0];

  always_comb begin
    sel_c  = SEL_R;
    max_c  = r5;
    diff_c = $signed({1'b0, g5}) - $signed({1'b0, b5});
    if (r5 >= g5 && r5 >= b5) begin
      sel_c  = SEL_R;
      max_c  = r5;
      diff_c = $signed({1'b0, g5}) - $signed({1'b0, b5});
    end else if (g5 >= b5) begin
      sel_c  = SEL_G;
      max_c  = g5;
      diff_c = $signed({1'b0, b5}) - $signed({1'b0, r5});
    end else begin
      sel_c  = SEL_B;
      max_c  = b5;
      diff_c = $signed({1'b0, r5}) - $signed({1'b0, g5});
    end
    min_c = r5;
    if (g5 < min_c) min_c = g5;
    if (b5 < min_c) min_c = b5;
  end

  logic              s1_valid;
  logic [4:0]        s1_max, s1_delta;
  sel_t              s1_sel;
  logic signed [5:0] s1_diff;
  logic [9:0]        s1_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_max   <= 5'd0;
      s1_delta <= 5'd0;
      s1_sel   <= SEL_R;
      s1_diff  <= 6'sd0;
      s1_cnt   <= 10'd0;
    end else begin
      s1_valid <= issue;
      if (issue) begin
        s1_max   <= max_c;
        s1_delta <= max_c - min_c;
        s1_sel   <= sel_c;
        s1_diff  <= diff_c;
        s1_cnt   <= pix_cnt;
      end
    end
  end

  logic [RW-1:0] recip60, recip31;
  logic [4:0]    abs_diff;
  logic [PW-1:0] mag_prod, sat_prod;

  hsv_recip_rom #(.FRAC(RECIP_FRAC)) u_rom (
    .delta   (s1_delta),
    .max_val (s1_max),
    .recip60 (recip60),
    .recip31 (recip31)
  );

  assign abs_diff = s1_diff[5] ? 5'(-s1_diff) : s1_diff[4:0];
  assign mag_prod = PW'(abs_diff) * PW'(recip60) + ROUND;
  assign sat_prod = PW'(s1_delta) * PW'(recip31) + ROUND;

  logic       s2_valid, s2_zero, s2_neg;
  logic [4:0] s2_max;
  sel_t       s2_sel;
  logic [6:0] s2_mag;
  logic [5:0] s2_sat;
  logic [9:0] s2_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_zero  <= 1'b0;
      s2_neg   <= 1'b0;
      s2_max   <= 5'd0;
      s2_sel   <= SEL_R;
      s2_mag   <= 7'd0;
      s2_sat   <= 6'd0;
      s2_cnt   <= 10'd0;
    end else begin
      s2_valid <= s1_valid && !cam_vsync;
      if (s1_valid) begin
        s2_zero <= (s1_delta == 5'd0);
        s2_neg  <= s1_diff[5];
        s2_max  <= s1_max;
        s2_sel  <= s1_sel;
        s2_mag  <= 7'(mag_prod >> RECIP_FRAC);
        s2_sat  <= 6'(sat_prod >> RECIP_FRAC);
        s2_cnt  <= s1_cnt;
      end
    end
  end

  // Hue may fall below zero only in the red sector; wrap it into 0..359.
  logic signed [10:0] hue_raw, hue_fix;

  always_comb begin
    hue_raw = $signed({2'b00, hue_base(s2_sel)}) +
              (s2_neg ? -$signed({4'b0000, s2_mag}) : $signed({4'b0000, s2_mag}));
    hue_fix = hue_raw;
    if (hue_raw < 11'sd0) begin
      hue_fix = hue_raw + $signed(11'(HUE_MAX));
    end else if (hue_raw >= $signed(11'(HUE_MAX))) begin
      hue_fix = hue_raw - $signed(11'(HUE_MAX));
    end
  end

  logic out_load;
  assign out_load = s2_valid && !cam_vsync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write       <= 1'b0;
      hue         <= 9'd0;
      saturation  <= 5'd0;
      value       <= 5'd0;
      horiz_count <= 10'd0;
    end else begin
      write <= out_load;
      if (out_load) begin
        horiz_count <= s2_cnt;
        value       <= s2_max;
        if (s2_zero) begin
          hue        <= 9'd0;
          saturation <= 5'd0;
        end else begin
          hue        <= 9'(hue_fix);
          saturation <= (s2_sat > 6'd31) ? 5'd31 : s2_sat[4:0];
        end
      end
    end
  end

`ifdef RGB_DEBUG_EN
  logic [15:0] s1_px, s2_px;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_px      <= 16'd0;
      s2_px      <= 16'd0;
      dbg_rgb565 <= 16'd0;
    end else begin
      if (issue)    s1_px      <= {hi_byte, cam_data};
      if (s1_valid) s2_px      <= s1_px;
      if (out_load) dbg_rgb565 <= s2_px;
    end
  end
`endif

endmodule
